text_entry_ctrl: RTL and testbench

Parametrised keypad-to-text-buffer controller: turns debounced button presses into glyph selection, character writes, space, delete, newline and full-screen clear on a COLS×ROWS character RAM. Sits between the button conditioning logic and the video text buffer write port. Generalises the fixed 40-column capture FSM with configurable geometry and glyph set, bidirectional glyph cycling, optional cursor wrap, and a multi-cycle clear sweep.

---
 rtl/text_ctrl_pkg.sv | 68 ++++++
 rtl/text_cursor.sv | 82 ++++++++
 rtl/text_entry_ctrl.sv | 168 ++++++++++++++++
 tb/tb_text_entry_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/text_ctrl_pkg.sv
// Shared types and helpers for the keypad-to-text-buffer controller:
// FSM states, latched-key codes and glyph code arithmetic.
package text_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_EXEC,
    S_CLEAR
  } state_e;

  typedef enum logic [2:0] {
    K_NONE,
    K_CLEAR,
    K_COMMIT,
    K_DELETE,
    K_NEWLINE,
    K_SPACE,
    K_NEXT,
    K_PREV
  } key_e;

  localparam int NUM_KEYS = 7;

  // Key vector bit order, highest priority first.
  localparam int KB_CLEAR   = 6;
  localparam int KB_COMMIT  = 5;
  localparam int KB_DELETE  = 4;
  localparam int KB_NEWLINE = 3;
  localparam int KB_SPACE   = 2;
  localparam int KB_NEXT    = 1;
  localparam int KB_PREV    = 0;

  function automatic key_e pick_key(input logic [NUM_KEYS-1:0] keys);
    key_e k;
    k = K_NONE;
    if (keys[KB_CLEAR])        k = K_CLEAR;
    else if (keys[KB_COMMIT])  k = K_COMMIT;
    else if (keys[KB_DELETE])  k = K_DELETE;
    else if (keys[KB_NEWLINE]) k = K_NEWLINE;
    else if (keys[KB_SPACE])   k = K_SPACE;
    else if (keys[KB_NEXT])    k = K_NEXT;
    else if (keys[KB_PREV])    k = K_PREV;
    return k;
  endfunction

  function automatic logic key_level(input key_e k, input logic [NUM_KEYS-1:0] keys);
    logic lvl;
    case (k)
      K_CLEAR:   lvl = keys[KB_CLEAR];
      K_COMMIT:  lvl = keys[KB_COMMIT];
      K_DELETE:  lvl = keys[KB_DELETE];
      K_NEWLINE: lvl = keys[KB_NEWLINE];
      K_SPACE:   lvl = keys[KB_SPACE];
      K_NEXT:    lvl = keys[KB_NEXT];
      K_PREV:    lvl = keys[KB_PREV];
      default:   lvl = 1'b0;
    endcase
    return lvl;
  endfunction

  function automatic logic [31:0] glyph_code(input int unsigned base,
                                             input int unsigned step,
                                             input int unsigned idx);
    return base + idx * step;
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor held as separate row/col counters; address is row*COLS+col.
// Saturates at the screen ends unless WRAP is set.
module text_cursor #(
  parameter int ADDR_W = 10,
  parameter int COLS   = 40,
  parameter int ROWS   = 14,
  parameter bit WRAP   = 1'b0
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              adv_i,
  input  logic              ret_i,
  input  logic              nl_i,
  input  logic              clr_i,
  output logic [ADDR_W-1:0] cursor_o,
  output logic              at_first_o,
  output logic              at_last_o
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (adv_i) begin
      if (col_q != COL_LAST) begin
        col_d = col_q + COL_ONE;
      end else if (row_q != ROW_LAST) begin
        col_d = '0;
        row_d = row_q + ROW_ONE;
      end else if (WRAP) begin
        col_d = '0;
        row_d = '0;
      end
    end else if (ret_i) begin
      if (col_q != '0) begin
        col_d = col_q - COL_ONE;
      end else if (row_q != '0) begin
        col_d = COL_LAST;
        row_d = row_q - ROW_ONE;
      end else if (WRAP) begin
        col_d = COL_LAST;
        row_d = ROW_LAST;
      end
    end else if (nl_i) begin
      // On the last row a newline either wraps to the top or leaves the cursor untouched.
      if (row_q != ROW_LAST) begin
        col_d = '0;
        row_d = row_q + ROW_ONE;
      end else if (WRAP) begin
        col_d = '0;
        row_d = '0;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign cursor_o   = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
  assign at_first_o = (row_q == '0) && (col_q == '0);
  assign at_last_o  = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/text_entry_ctrl.sv
// Keypad-to-text-buffer controller: release-triggered glyph select, write and edit commands.
// S_IDLE wait for key | S_HOLD key latched, wait release | S_EXEC one-cycle action | S_CLEAR blank sweep
import text_ctrl_pkg::*;

module text_entry_ctrl #(
  parameter int COLS        = 40,
  parameter int ROWS        = 14,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 12,
  parameter int GLYPH_BASE  = 512,
  parameter int GLYPH_STEP  = 32,
  parameter int GLYPH_COUNT = 22,
  parameter int BLANK       = 0,
  parameter bit WRAP        = 1'b0
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iNext,
  input  logic              iPrev,
  input  logic              iCommit,
  input  logic              iSpace,
  input  logic              iDelete,
  input  logic              iNewline,
  input  logic              iClear,
  output logic [ADDR_W-1:0] oAddr,
  output logic [DATA_W-1:0] oData,
  output logic              oWe,
  output logic [ADDR_W-1:0] oCursor,
  output logic [DATA_W-1:0] oGlyph,
  output logic              oBusy
);

  localparam int DEPTH = COLS * ROWS;
  localparam int IW    = (GLYPH_COUNT > 1) ? $clog2(GLYPH_COUNT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(GLYPH_COUNT - 1);
  localparam logic [IW-1:0]     IDX_ONE   = IW'(1);
  localparam logic [DATA_W-1:0] BLANK_C   = DATA_W'(BLANK);

  state_e              state_q;
  key_e                key_q;
  logic [IW-1:0]       idx_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;

  logic [NUM_KEYS-1:0] keys;
  logic [ADDR_W-1:0]   cursor;
  logic [ADDR_W-1:0]   del_addr;
  logic [DATA_W-1:0]   glyph;
  logic                at_first, at_last;
  logic                exec, can_del;
  logic                cur_adv, cur_ret, cur_nl, cur_clr;

  assign keys = {iClear, iCommit, iDelete, iNewline, iSpace, iNext, iPrev};

  assign glyph    = DATA_W'(glyph_code(GLYPH_BASE, GLYPH_STEP, 32'(idx_q)));
  assign can_del  = WRAP || !at_first;
  assign del_addr = at_first ? LAST_ADDR : cursor - ADDR_ONE;

  // Cursor moves at the end of the exec cycle, after the write has used its old value.
  assign exec    = (state_q == S_EXEC);
  assign cur_adv = exec && ((key_q == K_COMMIT) || (key_q == K_SPACE)) && (WRAP || !at_last);
  assign cur_ret = exec && (key_q == K_DELETE) && can_del;
  assign cur_nl  = exec && (key_q == K_NEWLINE);
  assign cur_clr = (state_q == S_CLEAR) && (addr_q == LAST_ADDR);

  text_cursor #(
    .ADDR_W (ADDR_W),
    .COLS   (COLS),
    .ROWS   (ROWS),
    .WRAP   (WRAP)
  ) u_cursor (
    .clk_sys    (iClk),
    .rst_n      (iRstN),
    .adv_i      (cur_adv),
    .ret_i      (cur_ret),
    .nl_i       (cur_nl),
    .clr_i      (cur_clr),
    .cursor_o   (cursor),
    .at_first_o (at_first),
    .at_last_o  (at_last)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= S_IDLE;
      key_q   <= K_NONE;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (|keys) begin
            key_q   <= pick_key(keys);
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!key_level(key_q, keys)) begin
            if (key_q == K_CLEAR) begin
              state_q <= S_CLEAR;
              we_q    <= 1'b1;
              addr_q  <= '0;
              data_q  <= BLANK_C;
            end else begin
              state_q <= S_EXEC;
              case (key_q)
                K_COMMIT: begin
                  we_q   <= 1'b1;
                  addr_q <= cursor;
                  data_q <= glyph;
                end
                K_SPACE: begin
                  we_q   <= 1'b1;
                  addr_q <= cursor;
                  data_q <= BLANK_C;
                end
                K_DELETE: begin
                  if (can_del) begin
                    we_q   <= 1'b1;
                    addr_q <= del_addr;
                    data_q <= BLANK_C;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        S_EXEC: begin
          state_q <= S_IDLE;
          case (key_q)
            K_NEXT:   idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
            K_PREV:   idx_q <= (idx_q == '0) ? IDX_LAST : idx_q - IDX_ONE;
            K_COMMIT: idx_q <= '0;
            default:  ;
          endcase
        end
        S_CLEAR: begin
          if (addr_q == LAST_ADDR) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
          end else begin
            we_q   <= 1'b1;
            addr_q <= addr_q + ADDR_ONE;
            data_q <= BLANK_C;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oWe     = we_q;
  assign oAddr   = addr_q;
  assign oData   = data_q;
  assign oCursor = cursor;
  assign oGlyph  = glyph;
  assign oBusy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_text_entry_ctrl.sv
// Directed bench for text_entry_ctrl: a saturating (u0) and a wrapping (u1) instance share stimulus.
module tb_text_entry_ctrl;

  localparam int KPREV = 0, KNEXT = 1, KSPACE = 2, KNL = 3, KDEL = 4, KCOMMIT = 5, KCLR = 6;

  logic       clk;
  logic       rst_n;
  logic [6:0] keys;

  logic [9:0]  addr0, cur0, addr1, cur1;
  logic [11:0] data0, gly0, data1, gly1;
  logic        we0, busy0, we1, busy1;

  logic        we0_c, we1_c;
  logic [9:0]  addr0_c, addr1_c;
  logic [11:0] data0_c, data1_c;

  int errors = 0;
  int checks = 0;

  text_entry_ctrl #(.WRAP(1'b0)) u0 (
    .iClk(clk), .iRstN(rst_n),
    .iNext(keys[KNEXT]), .iPrev(keys[KPREV]), .iCommit(keys[KCOMMIT]),
    .iSpace(keys[KSPACE]), .iDelete(keys[KDEL]), .iNewline(keys[KNL]), .iClear(keys[KCLR]),
    .oAddr(addr0), .oData(data0), .oWe(we0), .oCursor(cur0), .oGlyph(gly0), .oBusy(busy0)
  );

  text_entry_ctrl #(.WRAP(1'b1)) u1 (
    .iClk(clk), .iRstN(rst_n),
    .iNext(keys[KNEXT]), .iPrev(keys[KPREV]), .iCommit(keys[KCOMMIT]),
    .iSpace(keys[KSPACE]), .iDelete(keys[KDEL]), .iNewline(keys[KNL]), .iClear(keys[KCLR]),
    .oAddr(addr1), .oData(data1), .oWe(we1), .oCursor(cur1), .oGlyph(gly1), .oBusy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Press and release one key; captures the exec-cycle write port, returns back in idle.
  task automatic press(input int k);
    @(negedge clk);
    keys = 7'(1 << k);
    repeat (2) @(negedge clk);
    keys = '0;
    @(negedge clk);
    we0_c = we0; addr0_c = addr0; data0_c = data0;
    we1_c = we1; addr1_c = addr1; data1_c = data1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int bad;
    int t;
    int wseen;
    keys  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_we",    32'(we0),   0);
    chk("rst_addr",  32'(addr0), 0);
    chk("rst_data",  32'(data0), 0);
    chk("rst_cur",   32'(cur0),  0);
    chk("rst_glyph", 32'(gly0),  512);
    chk("rst_busy",  32'(busy0), 0);

    repeat (3) press(KNEXT);
    chk("next3_glyph", 32'(gly0), 608);
    press(KCOMMIT);
    chk("commit_we",    32'(we0_c),   1);
    chk("commit_addr",  32'(addr0_c), 0);
    chk("commit_data",  32'(data0_c), 608);
    chk("commit_cur",   32'(cur0),    1);
    chk("commit_glyph", 32'(gly0),    512);

    press(KPREV);
    chk("prev_wrap_glyph", 32'(gly0), 1184);
    chk("prev_no_we",      32'(we0_c), 0);
    press(KNEXT);
    chk("next_wrap_glyph", 32'(gly0), 512);

    press(KDEL);
    chk("del1_we",   32'(we0_c),   1);
    chk("del1_addr", 32'(addr0_c), 0);
    chk("del1_cur",  32'(cur0),    0);
    press(KDEL);
    chk("del0_sat_we",   32'(we0_c),   0);
    chk("del0_sat_cur",  32'(cur0),    0);
    chk("del0_wrap_we",  32'(we1_c),   1);
    chk("del0_wrap_addr",32'(addr1_c), 559);
    chk("del0_wrap_data",32'(data1_c), 0);
    chk("del0_wrap_cur", 32'(cur1),    559);

    do_reset();
    repeat (5) press(KSPACE);
    chk("space_addr", 32'(addr0_c), 4);
    chk("space_data", 32'(data0_c), 0);
    chk("space5_cur", 32'(cur0),    5);
    press(KDEL);
    chk("del5_we",   32'(we0_c),   1);
    chk("del5_addr", 32'(addr0_c), 4);
    chk("del5_data", 32'(data0_c), 0);
    chk("del5_cur",  32'(cur0),    4);

    do_reset();
    press(KNL);
    repeat (5) press(KSPACE);
    chk("cur45", 32'(cur0), 45);
    press(KNL);
    chk("nl45_cur", 32'(cur0),  80);
    chk("nl45_we",  32'(we0_c), 0);
    repeat (11) press(KNL);
    chk("nl_row13", 32'(cur0), 520);
    press(KNL);
    chk("nl_last_sat",  32'(cur0), 520);
    chk("nl_last_wrap", 32'(cur1), 0);

    do_reset();
    repeat (13) press(KNL);
    repeat (39) press(KSPACE);
    chk("cur559", 32'(cur0), 559);
    press(KSPACE);
    chk("sp559_sat_we",   32'(we0_c),   1);
    chk("sp559_sat_addr", 32'(addr0_c), 559);
    chk("sp559_sat_cur",  32'(cur0),    559);
    chk("sp559_wrap_we",  32'(we1_c),   1);
    chk("sp559_wrap_addr",32'(addr1_c), 559);
    chk("sp559_wrap_cur", 32'(cur1),    0);

    press(KNEXT);
    chk("pre_clear_glyph", 32'(gly0), 544);

    // Clear with iNext held alongside; iNext released part-way through the sweep.
    @(negedge clk);
    keys = 7'b1000010;
    repeat (2) @(negedge clk);
    keys = 7'b0000010;
    t = 0;
    while (!we0 && t < 8) begin
      @(negedge clk);
      t++;
    end
    chk("clear_start", 32'(we0), 1);
    bad = 0;
    for (int k = 0; k < 560; k++) begin
      if (!(we0 === 1'b1 && addr0 === 10'(k) && data0 === 12'd0 && busy0 === 1'b1)) bad++;
      if (k == 50) keys = '0;
      @(negedge clk);
    end
    chk("clear_sweep_bad", bad, 0);
    chk("clear_end_we",    32'(we0),   0);
    chk("clear_end_busy",  32'(busy0), 0);
    chk("clear_end_cur",   32'(cur0),  0);
    chk("clear_end_glyph", 32'(gly0),  512);
    chk("clear_wrap_cur",  32'(cur1),  0);
    repeat (4) @(negedge clk);
    chk("clear_next_ignored", 32'(gly0), 512);

    // Reset at sweep cycle 100.
    press(KCLR);
    t = 0;
    while (!(we0 === 1'b1 && addr0 === 10'd100) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("sweep100_reached", 32'(addr0), 100);
    rst_n = 1'b0;
    #1;
    chk("rst_sweep_we",   32'(we0),   0);
    chk("rst_sweep_addr", 32'(addr0), 0);
    chk("rst_sweep_busy", 32'(busy0), 0);
    chk("rst_sweep_cur",  32'(cur0),  0);
    wseen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 3) rst_n = 1'b1;
      if (we0 !== 1'b0 || busy0 !== 1'b0) wseen++;
    end
    chk("post_rst_quiet", wseen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
